// File: rtl/markov_merge_n.sv
// markov_merge_n
//   Merges two N-th order Markov transition-count tables (A and B) into one
//   internal table. A is copied verbatim; each B entry is then searched for
//   linearly: a hit adds its count to the existing entry, a miss appends it.
//   The merged table is read back through a combinational random-access port.
//
//   Optional feature macro: MARKOV_MERGE_SAT_EN
//     defined   : count additions clamp to 2^CNT_W-1 and set the sticky
//                 'saturated' flag when clamping happens
//     undefined : count additions wrap modulo 2^CNT_W, 'saturated' stays 0
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   start                 begin a merge (sampled in INIT and FINISH)
//   a_valid/a_ready/a_key/a_count/a_last   A table stream
//   b_valid/b_ready/b_key/b_count/b_last   B table stream
//   rd_addr -> rd_key, rd_count            combinational table read
//   out_len               number of valid entries in the table
//   overflow              sticky: an entry was dropped on a full table
//   saturated             sticky: a count was clamped
//   done                  merge complete (held in FINISH)
module markov_merge_n #(
  parameter int SYM_W = 4,
  parameter int ORDER = 1,
  parameter int CNT_W = 16,
  parameter int DEPTH = 64,
  parameter int KEY_W = (ORDER + 1) * SYM_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [KEY_W-1:0] a_key,
  input  logic [CNT_W-1:0] a_count,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [KEY_W-1:0] b_key,
  input  logic [CNT_W-1:0] b_count,
  input  logic             b_last,
  input  logic [AW-1:0]    rd_addr,
  output logic [KEY_W-1:0] rd_key,
  output logic [CNT_W-1:0] rd_count,
  output logic [AW:0]      out_len,
  output logic             overflow,
  output logic             saturated,
  output logic             done
);

`ifdef MARKOV_MERGE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_INIT,
    S_COPY_A,
    S_MERGE_B,
    S_SEARCH,
    S_INC_COUNT,
    S_ADD_TO_LIST,
    S_FINISH
  } state_t;

  // Widened sum so the carry out is visible to the clamp logic.
  function automatic logic [CNT_W:0] add_cnt(input logic [CNT_W-1:0] x,
                                             input logic [CNT_W-1:0] y);
    add_cnt = {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W:0] s);
    if (SAT_EN && s[CNT_W]) clamp_cnt = '1;
    else                    clamp_cnt = s[CNT_W-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [AW:0]      out_len_q, out_len_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             a_ready_q, a_ready_d;
  logic             b_ready_q, b_ready_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic             sat_q, sat_d;
  logic             blast_q, blast_d;
  logic [KEY_W-1:0] bkey_q, bkey_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;

  logic [KEY_W-1:0] key_mem [DEPTH];
  logic [CNT_W-1:0] cnt_mem [DEPTH];

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [KEY_W-1:0] wr_key;
  logic [CNT_W-1:0] wr_cnt;

  logic             hit;
  logic             at_last;
  logic             has_room;
  logic [CNT_W:0]   sum;

  assign hit      = (key_mem[idx_q] == bkey_q);
  assign at_last  = ({1'b0, idx_q} == (out_len_q - (AW + 1)'(1)));
  assign has_room = (out_len_q < DEPTH_L);
  assign sum      = add_cnt(cnt_mem[idx_q], bcnt_q);

  always_comb begin
    state_d    = state_q;
    out_len_d  = out_len_q;
    idx_d      = idx_q;
    a_ready_d  = a_ready_q;
    b_ready_d  = b_ready_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    sat_d      = sat_q;
    blast_d    = blast_q;
    bkey_d     = bkey_q;
    bcnt_d     = bcnt_q;
    wr_en      = 1'b0;
    wr_addr    = out_len_q[AW-1:0];
    wr_key     = a_key;
    wr_cnt     = a_count;

    case (state_q)
      S_INIT, S_FINISH: begin
        if (start) begin
          state_d    = S_COPY_A;
          out_len_d  = '0;
          done_d     = 1'b0;
          overflow_d = 1'b0;
          sat_d      = 1'b0;
          a_ready_d  = 1'b1;
        end
      end

      S_COPY_A: begin
        if (a_valid) begin
          if (has_room) begin
            wr_en     = 1'b1;
            out_len_d = out_len_q + (AW + 1)'(1);
          end else begin
            overflow_d = 1'b1;
          end
          if (a_last) begin
            state_d   = S_MERGE_B;
            a_ready_d = 1'b0;
            b_ready_d = 1'b1;
          end
        end
      end

      S_MERGE_B: begin
        if (b_valid) begin
          bkey_d    = b_key;
          bcnt_d    = b_count;
          blast_d   = b_last;
          idx_d     = '0;
          b_ready_d = 1'b0;
          state_d   = (out_len_q == '0) ? S_ADD_TO_LIST : S_SEARCH;
        end
      end

      S_SEARCH: begin
        if (hit)          state_d = S_INC_COUNT;
        else if (at_last) state_d = S_ADD_TO_LIST;
        else              idx_d   = idx_q + AW'(1);
      end

      S_INC_COUNT, S_ADD_TO_LIST: begin
        wr_key = bkey_q;
        if (state_q == S_INC_COUNT) begin
          wr_en   = 1'b1;
          wr_addr = idx_q;
          wr_cnt  = clamp_cnt(sum);
          sat_d   = sat_q | (SAT_EN & sum[CNT_W]);
        end else if (has_room) begin
          wr_en     = 1'b1;
          wr_cnt    = bcnt_q;
          out_len_d = out_len_q + (AW + 1)'(1);
        end else begin
          overflow_d = 1'b1;
        end
        if (blast_q) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else begin
          state_d   = S_MERGE_B;
          b_ready_d = 1'b1;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INIT;
      out_len_q  <= '0;
      idx_q      <= '0;
      a_ready_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      sat_q      <= 1'b0;
      blast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_len_q  <= out_len_d;
      idx_q      <= idx_d;
      a_ready_q  <= a_ready_d;
      b_ready_q  <= b_ready_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      sat_q      <= sat_d;
      blast_q    <= blast_d;
    end
  end

  // Latched B beat and table storage carry no reset; their contents are only
  // meaningful once the control path has written them.
  always_ff @(posedge clk) begin
    bkey_q <= bkey_d;
    bcnt_q <= bcnt_d;
    if (wr_en) begin
      key_mem[wr_addr] <= wr_key;
      cnt_mem[wr_addr] <= wr_cnt;
    end
  end

  assign a_ready   = a_ready_q;
  assign b_ready   = b_ready_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign saturated = sat_q;
  assign out_len   = out_len_q;
  assign rd_key    = key_mem[rd_addr];
  assign rd_count  = cnt_mem[rd_addr];

endmodule

// File: tb/tb_markov_merge_n.sv
module tb_markov_merge_n;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  int          sel = 0;
  logic        a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
  logic [7:0]  a_key = '0, b_key = '0;
  logic [15:0] a_count = '0, b_count = '0;
  logic [5:0]  rd_addr = '0;

  // Instance 0: default geometry. Instance 1: DEPTH=4, CNT_W=4.
  logic        a_ready0, b_ready0, ovf0, sat0, done0;
  logic [7:0]  rd_key0;
  logic [15:0] rd_cnt0;
  logic [6:0]  len0;
  logic        a_ready1, b_ready1, ovf1, sat1, done1;
  logic [7:0]  rd_key1;
  logic [3:0]  rd_cnt1;
  logic [2:0]  len1;

  logic start0, start1, av0, av1, bv0, bv1;
  assign start0 = start && (sel == 0);
  assign start1 = start && (sel == 1);
  assign av0 = a_valid && (sel == 0);
  assign av1 = a_valid && (sel == 1);
  assign bv0 = b_valid && (sel == 0);
  assign bv1 = b_valid && (sel == 1);

  logic        a_ready_m, b_ready_m, ovf_m, sat_m, done_m;
  logic [7:0]  rd_key_m;
  logic [15:0] rd_cnt_m;
  logic [6:0]  len_m;
  assign a_ready_m = sel == 1 ? a_ready1 : a_ready0;
  assign b_ready_m = sel == 1 ? b_ready1 : b_ready0;
  assign ovf_m     = sel == 1 ? ovf1 : ovf0;
  assign sat_m     = sel == 1 ? sat1 : sat0;
  assign done_m    = sel == 1 ? done1 : done0;
  assign rd_key_m  = sel == 1 ? rd_key1 : rd_key0;
  assign rd_cnt_m  = sel == 1 ? {12'b0, rd_cnt1} : rd_cnt0;
  assign len_m     = sel == 1 ? {4'b0, len1} : len0;

  markov_merge_n dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .a_valid(av0), .a_ready(a_ready0), .a_key(a_key), .a_count(a_count), .a_last(a_last),
    .b_valid(bv0), .b_ready(b_ready0), .b_key(b_key), .b_count(b_count), .b_last(b_last),
    .rd_addr(rd_addr), .rd_key(rd_key0), .rd_count(rd_cnt0), .out_len(len0),
    .overflow(ovf0), .saturated(sat0), .done(done0));

  markov_merge_n #(.CNT_W(4), .DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .a_valid(av1), .a_ready(a_ready1), .a_key(a_key), .a_count(a_count[3:0]), .a_last(a_last),
    .b_valid(bv1), .b_ready(b_ready1), .b_key(b_key), .b_count(b_count[3:0]), .b_last(b_last),
    .rd_addr(rd_addr[1:0]), .rd_key(rd_key1), .rd_count(rd_cnt1), .out_len(len1),
    .overflow(ovf1), .saturated(sat1), .done(done1));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int               sel;
    int               na;
    int               nb;
    logic [5:0][7:0]  ak;
    logic [5:0][15:0] ac;
    logic [1:0][7:0]  bk;
    logic [1:0][15:0] bc;
    logic [1:0][7:0]  bcyc;
    int               elen;
    logic [5:0][7:0]  ek;
    logic [5:0][15:0] ec;
    logic             eovf;
    logic             esat;
  } vec_t;

  vec_t vecs[6];

  task automatic va(input int i, input int j, input logic [7:0] k, input logic [15:0] c);
    vecs[i].ak[j] = k; vecs[i].ac[j] = c; vecs[i].na = j + 1;
  endtask
  task automatic vb(input int i, input int j, input logic [7:0] k, input logic [15:0] c,
                    input logic [7:0] cyc);
    vecs[i].bk[j] = k; vecs[i].bc[j] = c; vecs[i].bcyc[j] = cyc; vecs[i].nb = j + 1;
  endtask
  task automatic ve(input int i, input int j, input logic [7:0] k, input logic [15:0] c);
    vecs[i].ek[j] = k; vecs[i].ec[j] = c; vecs[i].elen = j + 1;
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_a(input logic [7:0] k, input logic [15:0] c, input logic l);
    int n = 0;
    a_valid = 1'b1; a_key = k; a_count = c; a_last = l;
    while (!a_ready_m && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("a_accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  // Returns the cycle cost of one B beat: accept cycle through update cycle.
  task automatic send_b(input logic [7:0] k, input logic [15:0] c, input logic l,
                        output int cyc);
    int n = 0;
    b_valid = 1'b1; b_key = k; b_count = c; b_last = l;
    while (!b_ready_m && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("b_accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    b_valid = 1'b0;
    cyc = 1;
    while (!(b_ready_m || done_m) && cyc < 500) begin @(negedge clk); cyc++; end
    if (cyc >= 500) check("b_resolve_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int cyc;
    sel = vecs[i].sel;
    @(negedge clk);
    pulse_start();
    for (int j = 0; j < vecs[i].na; j++)
      send_a(vecs[i].ak[j], vecs[i].ac[j], j == vecs[i].na - 1);
    for (int j = 0; j < vecs[i].nb; j++) begin
      send_b(vecs[i].bk[j], vecs[i].bc[j], j == vecs[i].nb - 1, cyc);
      check($sformatf("v%0d_bcycles%0d", i, j), cyc, vecs[i].bcyc[j]);
    end
    check($sformatf("v%0d_done", i), done_m, 1);
    check($sformatf("v%0d_out_len", i), len_m, vecs[i].elen);
    check($sformatf("v%0d_overflow", i), ovf_m, vecs[i].eovf);
    check($sformatf("v%0d_saturated", i), sat_m, vecs[i].esat);
    for (int j = 0; j < vecs[i].elen; j++) begin
      rd_addr = 6'(j);
      #1;
      check($sformatf("v%0d_key%0d", i, j), rd_key_m, vecs[i].ek[j]);
      check($sformatf("v%0d_cnt%0d", i, j), rd_cnt_m, vecs[i].ec[j]);
    end
  endtask

  initial begin
    int cyc;

    // Disjoint merge
    vecs[0].sel = 0;
    va(0, 0, 8'h12, 5); va(0, 1, 8'h34, 7);
    vb(0, 0, 8'h56, 2, 4);
    ve(0, 0, 8'h12, 5); ve(0, 1, 8'h34, 7); ve(0, 2, 8'h56, 2);
    vecs[0].eovf = 0; vecs[0].esat = 0;
    // Matching merge: 0x34 hits idx1 (4 cycles), 0x12 hits idx0 (3 cycles)
    vecs[1].sel = 0;
    va(1, 0, 8'h12, 5); va(1, 1, 8'h34, 7);
    vb(1, 0, 8'h34, 3, 4); vb(1, 1, 8'h12, 1, 3);
    ve(1, 0, 8'h12, 6); ve(1, 1, 8'h34, 10);
    vecs[1].eovf = 0; vecs[1].esat = 0;
    // Full table (DEPTH=4): miss searches 4 then drops, hit at idx1
    vecs[2].sel = 1;
    va(2, 0, 8'h11, 1); va(2, 1, 8'h22, 2); va(2, 2, 8'h33, 3); va(2, 3, 8'h44, 4);
    vb(2, 0, 8'h99, 1, 6); vb(2, 1, 8'h22, 2, 4);
    ve(2, 0, 8'h11, 1); ve(2, 1, 8'h22, 4); ve(2, 2, 8'h33, 3); ve(2, 3, 8'h44, 4);
    vecs[2].eovf = 1; vecs[2].esat = 0;
    // Count saturation / wrap (CNT_W=4): 14+5
    vecs[3].sel = 1;
    va(3, 0, 8'h12, 14);
    vb(3, 0, 8'h12, 5, 3);
`ifdef MARKOV_MERGE_SAT_EN
    ve(3, 0, 8'h12, 15); vecs[3].esat = 1;
`else
    ve(3, 0, 8'h12, 3);  vecs[3].esat = 0;
`endif
    vecs[3].eovf = 0;
    // A overflows in COPY_A: fifth beat dropped, B re-offers it and is dropped too
    vecs[4].sel = 1;
    va(4, 0, 8'h11, 1); va(4, 1, 8'h22, 2); va(4, 2, 8'h33, 3); va(4, 3, 8'h44, 4);
    va(4, 4, 8'h55, 5);
    vb(4, 0, 8'h55, 1, 6);
    ve(4, 0, 8'h11, 1); ve(4, 1, 8'h22, 2); ve(4, 2, 8'h33, 3); ve(4, 3, 8'h44, 4);
    vecs[4].eovf = 1; vecs[4].esat = 0;
    // Duplicate key in A kept twice; B updates the first copy only
    vecs[5].sel = 0;
    va(5, 0, 8'h12, 1); va(5, 1, 8'h12, 2);
    vb(5, 0, 8'h12, 4, 3);
    ve(5, 0, 8'h12, 5); ve(5, 1, 8'h12, 2);
    vecs[5].eovf = 0; vecs[5].esat = 0;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_out_len", len_m, 0);
    check("rst_done", done_m, 0);
    check("rst_a_ready", a_ready_m, 0);
    check("rst_b_ready", b_ready_m, 0);
    check("rst_overflow", ovf_m, 0);
    check("rst_saturated", sat_m, 0);

    // valid outside an accepting state is ignored
    a_valid = 1'b1; a_last = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ignores_a", len_m, 0);
    a_valid = 1'b0; a_last = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset in the middle of SEARCH
    sel = 0;
    @(negedge clk);
    pulse_start();
    send_a(8'h01, 1, 1'b0); send_a(8'h02, 1, 1'b0); send_a(8'h03, 1, 1'b1);
    b_valid = 1'b1; b_key = 8'h04; b_count = 1; b_last = 1'b1;
    while (!b_ready_m) @(negedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    check("mid_pre_len", len_m, 3);
    reset = 1'b0;
    #1;
    check("mid_rst_len", len_m, 0);
    check("mid_rst_done", done_m, 0);
    check("mid_rst_a_ready", a_ready_m, 0);
    check("mid_rst_b_ready", b_ready_m, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_post_idle", a_ready_m, 0);
    run_vec(0);

    // Back-to-back restart from FINISH with a_valid already high
    start = 1'b1; a_valid = 1'b1; a_key = 8'h77; a_count = 9; a_last = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_low", done_m, 0);
    check("b2b_a_ready", a_ready_m, 1);
    check("b2b_len_cleared", len_m, 0);
    @(negedge clk);
    a_valid = 1'b0;
    check("b2b_len_one", len_m, 1);
    check("b2b_b_ready", b_ready_m, 1);
    send_b(8'h77, 1, 1'b1, cyc);
    check("b2b_bcycles", cyc, 3);
    rd_addr = 0;
    #1;
    check("b2b_key", rd_key_m, 8'h77);
    check("b2b_cnt", rd_cnt_m, 10);
    check("b2b_done", done_m, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/markov_merge_n.md
Name: markov_merge_n

Overview:
- Parametrised successor to the first-order merge engine. Merges two N-th order Markov transition-count tables, A and B, into one internal output table.
- Each table entry is {key = ORDER prefix symbols plus next symbol, count}.
- A is copied into the table verbatim. Each B entry is then searched for: on a match its count is added to the existing entry, otherwise it is appended.
- Sits between the per-stream Markov model builders and the model store. The store reads the merged table back through a random-access port.

Parameters:
- SYM_W, 4, bits per symbol
- ORDER, 1, Markov order (prefix length in symbols); KEY_W = (ORDER+1)*SYM_W
- CNT_W, 16, count width
- DEPTH, 64, output table capacity in entries; AW = clog2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a merge; sampled in INIT and FINISH only
- a_valid  in  1  A beat valid
- a_ready  out  1  A beat accepted when a_valid&&a_ready
- a_key  in  KEY_W  A entry key
- a_count  in  CNT_W  A entry count
- a_last  in  1  final A beat
- b_valid  in  1  B beat valid
- b_ready  out  1  B beat accepted when b_valid&&b_ready
- b_key  in  KEY_W  B entry key
- b_count  in  CNT_W  B entry count
- b_last  in  1  final B beat
- rd_addr  in  AW  output table read index
- rd_key  out  KEY_W  key at rd_addr (combinational)
- rd_count  out  CNT_W  count at rd_addr (combinational)
- out_len  out  AW+1  number of valid entries
- overflow  out  1  sticky: at least one entry dropped because the table was full
- saturated  out  1  sticky: at least one count clamped
- done  out  1  merge complete

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INIT
  - out_len=0, done=0, overflow=0, saturated=0
  - a_ready=0, b_ready=0
  - table contents don't-care
- Reset mid-operation aborts the merge. Partial results are discarded (out_len=0).
- A and B each always deliver at least one beat, the last beat flagged with *_last.
- Keys within A must be unique; duplicates in A are stored as separate entries.
- INIT: idle. On start: clear out_len and flags, done=0, go to COPY_A.
- COPY_A (a_ready=1):
  - Each accepted beat writes entry[out_len] and increments out_len.
  - If out_len==DEPTH, the beat is dropped and overflow is set.
  - Accepted beat with a_last: go to MERGE_B.
  - One beat per cycle maximum.
- MERGE_B (b_ready=1):
  - Accept a beat and latch key, count and last; set idx=0.
  - If out_len==0, go to ADD_TO_LIST; otherwise go to SEARCH.
- SEARCH (b_ready=0): one comparison per cycle against entry[idx].
  - Key match: go to INC_COUNT.
  - Else if idx==out_len-1: go to ADD_TO_LIST.
  - Else idx++.
- INC_COUNT: entry[idx].count += latched count. Width rule: CNT_W+1-bit sum; see the optional feature for the overflow case.
- ADD_TO_LIST:
  - If out_len<DEPTH, write entry[out_len] and increment out_len.
  - Else drop the entry and set overflow.
- Exit from INC_COUNT and ADD_TO_LIST: go to FINISH if the latched last is set, else go to MERGE_B.
- Per-B-beat cost: 1 accept cycle, plus m search cycles (m = matching index+1, or out_len on a miss), plus 1 update cycle.
  - A match at idx k costs k+3 cycles.
  - A miss costs out_len+2 cycles, or 2 cycles if the table is empty.
- FINISH: done=1, held. start clears done, clears out_len and flags, and goes to COPY_A. Otherwise FINISH is held.
- The read port is live in every state but only meaningful in FINISH. rd_addr>=out_len returns don't-care.
- a_valid/b_valid asserted outside their accepting state are ignored, with no acceptance.

Optional Feature:
- Macro: MARKOV_MERGE_SAT_EN.
- Defined:
  - INC_COUNT clamps the sum to 2^CNT_W-1 and sets saturated when the true sum exceeds that value.
  - A counts in COPY_A are taken as-is.
- Undefined:
  - Sums wrap modulo 2^CNT_W.
  - saturated is tied to 0.

Test Plan:
- Reset mid-SEARCH (DEPTH=64, A=3 beats, B in progress): drop reset -> out_len=0, done=0, a_ready=b_ready=0 immediately; after release, start runs a clean merge.
- Disjoint merge (SYM_W=4, ORDER=1): A={0x12:5, 0x34:7}, B={0x56:2} -> out_len=3, entries [0x12:5, 0x34:7, 0x56:2], done=1, B beat takes 4 cycles (accept + 2 search + add).
- Matching merge: A={0x12:5, 0x34:7}, B={0x34:3, 0x12:1} -> out_len=2, counts 0x12:6, 0x34:10; second B beat resolves at idx 0 in 3 cycles.
- Full table (DEPTH=4): A=4 unique keys, B={new 0x99:1, existing key:+2} -> overflow=1, out_len=4, the existing key's count incremented by 2, and 0x99 absent.
- Saturation (CNT_W=4, MARKOV_MERGE_SAT_EN defined): A={0x12:14}, B={0x12:5} -> count=15, saturated=1; macro undefined -> count=3, saturated=0.
- Back-to-back restart: start asserted in FINISH with a_valid held high -> done falls the next cycle, the first A beat is accepted in the COPY_A cycle, and out_len restarts from 0.
